// File: rtl/int_closest_hit.sv
// Closest-hit reduction stage: qualifies per-triangle results against t_max,
// keeps the nearest hit of each ray's contiguous beats and queues one result
// per ray in an output FIFO with an early stall request to the issue logic.
module int_closest_hit #(
  parameter int unsigned RAYID_W      = 9,
  parameter int unsigned TRIID_W      = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STALL_MARGIN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_hit,
  input  logic [31:0]        in_t,
  input  logic [63:0]        in_uv,
  input  logic [TRIID_W-1:0] in_tri_id,
  input  logic [RAYID_W-1:0] in_ray_id,
  input  logic [31:0]        in_t_max,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RAYID_W-1:0] out_ray_id,
  output logic               out_hit,
  output logic [31:0]        out_t,
  output logic [63:0]        out_uv,
  output logic [TRIID_W-1:0] out_tri_id,
  output logic               stall_req,
  output logic               err_seq,
  output logic               err_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  // Occupancy at which free entries drop to STALL_MARGIN or below.
  localparam int unsigned StallLevel =
      (FIFO_DEPTH > STALL_MARGIN) ? (FIFO_DEPTH - STALL_MARGIN) : 0;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StAccum = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [RAYID_W-1:0] open_ray_q, open_ray_d;
  logic               best_hit_q, best_hit_d;
  logic [31:0]        best_t_q, best_t_d;
  logic [63:0]        best_uv_q, best_uv_d;
  logic [TRIID_W-1:0] best_tri_q, best_tri_d;
  logic               err_seq_q, err_seq_d;
  logic               err_ovf_q;

  logic               cand, better;
  logic               push;
  logic [RAYID_W-1:0] push_ray;
  logic               push_hit;
  logic [31:0]        push_t;
  logic [63:0]        push_uv;
  logic [TRIID_W-1:0] push_tri;

  // t_max is always positive, so its sign bit carries no information.
  logic unused_tmax_sign;
  assign unused_tmax_sign = in_t_max[31];

  // Positive floats order like their magnitude bits, so an integer compare suffices.
  assign cand   = in_valid & in_hit & ~in_t[31] & (in_t[30:0] < in_t_max[30:0]);
  // Strict less-than keeps the earlier triangle on a tie.
  assign better = cand & (~best_hit_q | (in_t[30:0] < best_t_q[30:0]));

  // Accumulator next state and the result to emit this cycle.
  always_comb begin
    state_d    = state_q;
    open_ray_d = open_ray_q;
    best_hit_d = best_hit_q;
    best_t_d   = best_t_q;
    best_uv_d  = best_uv_q;
    best_tri_d = best_tri_q;
    err_seq_d  = err_seq_q;
    push       = 1'b0;
    push_ray   = open_ray_q;
    push_hit   = best_hit_q;
    push_t     = best_t_q;
    push_uv    = best_uv_q;
    push_tri   = best_tri_q;
    if (in_valid) begin
      if ((state_q == StAccum) && (in_ray_id == open_ray_q)) begin
        if (better) begin
          best_hit_d = 1'b1;
          best_t_d   = in_t;
          best_uv_d  = in_uv;
          best_tri_d = in_tri_id;
        end
        if (in_last) begin
          state_d = StIdle;
          push    = 1'b1;
        end
      end else begin
        // Ray changed without a last beat: flush the open ray as-is.
        if (state_q == StAccum) begin
          err_seq_d = 1'b1;
          push      = 1'b1;
        end
        open_ray_d = in_ray_id;
        best_hit_d = cand;
        best_t_d   = cand ? in_t      : '0;
        best_uv_d  = cand ? in_uv     : '0;
        best_tri_d = cand ? in_tri_id : '0;
        // A closing first beat wins the single write port over a stale flush.
        if (in_last) begin
          state_d = StIdle;
          push    = 1'b1;
        end else begin
          state_d = StAccum;
        end
      end
      if (push && (state_d == StIdle)) begin
        push_ray = in_ray_id;
        push_hit = best_hit_d;
        push_t   = best_t_d;
        push_uv  = best_uv_d;
        push_tri = best_tri_d;
      end
    end
  end

  // Accumulator and sequence-error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      open_ray_q <= '0;
      best_hit_q <= 1'b0;
      best_t_q   <= '0;
      best_uv_q  <= '0;
      best_tri_q <= '0;
      err_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      open_ray_q <= open_ray_d;
      best_hit_q <= best_hit_d;
      best_t_q   <= best_t_d;
      best_uv_q  <= best_uv_d;
      best_tri_q <= best_tri_d;
      err_seq_q  <= err_seq_d;
    end
  end

  logic [RAYID_W-1:0] mem_ray [FIFO_DEPTH];
  logic               mem_hit [FIFO_DEPTH];
  logic [31:0]        mem_t   [FIFO_DEPTH];
  logic [63:0]        mem_uv  [FIFO_DEPTH];
  logic [TRIID_W-1:0] mem_tri [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               out_valid_q, stall_q;
  logic               full, do_pop, do_push;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = out_valid_q & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  // FIFO storage, pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_ray[i] <= '0;
        mem_hit[i] <= 1'b0;
        mem_t[i]   <= '0;
        mem_uv[i]  <= '0;
        mem_tri[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_ray[wr_ptr_q] <= push_ray;
        mem_hit[wr_ptr_q] <= push_hit;
        mem_t[wr_ptr_q]   <= push_t;
        mem_uv[wr_ptr_q]  <= push_uv;
        mem_tri[wr_ptr_q] <= push_tri;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !do_push) begin
        err_ovf_q <= 1'b1;
      end
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      stall_q     <= (32'(count_d) >= StallLevel);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ray_id = mem_ray[rd_ptr_q];
  assign out_hit    = mem_hit[rd_ptr_q];
  assign out_t      = mem_t[rd_ptr_q];
  assign out_uv     = mem_uv[rd_ptr_q];
  assign out_tri_id = mem_tri[rd_ptr_q];
  assign stall_req  = stall_q;
  assign err_seq    = err_seq_q;
  assign err_ovf    = err_ovf_q;

endmodule
